// File: rtl/bn_pkg.sv
// Shared definitions for the batch-norm scheduler: FSM states, fp16 constants,
// default parameter values and the vectors-per-channel normalisation helper.
package bn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } bn_state_e;

  localparam logic [15:0] FP16_ONE  = 16'h3C00;
  localparam logic [15:0] FP16_ZERO = 16'h0000;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_SIZE       = 4;
  localparam int DEF_CHANNELS   = 16;
  localparam int DEF_BN_LATENCY = 8;
  localparam int DEF_FIFO_DEPTH = 16;

  // A programmed count of zero behaves as a single vector per channel.
  function automatic logic [15:0] eff_vpc(input logic [15:0] v);
    eff_vpc = (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/bn_sched_fifo.sv
// First-word-fall-through result buffer for bn_scheduler; DEPTH must be a power of two.
module bn_sched_fifo
  import bn_pkg::*;
#(
  parameter int WIDTH = 65,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push_s, do_pop_s;

  // Pointer and occupancy update; a push into a full buffer is taken only alongside a pop.
  always_comb begin
    do_pop_s  = pop && (count_q != '0);
    do_push_s = push && ((count_q != FULL_CNT) || do_pop_s);
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, deliberately not reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Head presentation.
  always_comb begin
    out_valid = (count_q != '0);
    if (out_valid) begin
      out_data = mem_q[rd_ptr_q];
    end else begin
      out_data = '0;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/bn_scheduler.sv
// Batch-norm scheduler: issues vectors with per-channel gamma/beta to a fixed-latency
// datapath and buffers results with credit flow control. Optional BN_SCHED_PERF_EN adds stall counters.
module bn_scheduler
  import bn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SIZE       = DEF_SIZE,
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int BN_LATENCY = DEF_BN_LATENCY,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [15:0]                   vec_per_ch,
  output logic                          busy,
  output logic                          done,
  input  logic                          cfg_we,
  input  logic [$clog2(CHANNELS)-1:0]   cfg_addr,
  input  logic [DATA_WIDTH-1:0]         cfg_gamma,
  input  logic [DATA_WIDTH-1:0]         cfg_beta,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH*SIZE-1:0]    in_data,
  output logic                          bn_valid,
  output logic [DATA_WIDTH*SIZE-1:0]    bn_x,
  output logic [DATA_WIDTH-1:0]         bn_gamma,
  output logic [DATA_WIDTH-1:0]         bn_beta,
  input  logic [DATA_WIDTH*SIZE-1:0]    bn_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH*SIZE-1:0]    out_data,
  output logic                          out_last
`ifdef BN_SCHED_PERF_EN
  ,
  output logic [31:0]                   stall_in_cnt,
  output logic [31:0]                   stall_out_cnt
`endif
);

  localparam int VW = DATA_WIDTH * SIZE;
  localparam int CW = $clog2(CHANNELS);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(FIFO_DEPTH) + 2;

  logic [DATA_WIDTH-1:0] gamma_mem_q [CHANNELS];
  logic [DATA_WIDTH-1:0] beta_mem_q  [CHANNELS];

  bn_state_e             state_q, state_d;
  logic [15:0]           vpc_q, vpc_d;
  logic [15:0]           vec_cnt_q, vec_cnt_d;
  logic [CW-1:0]         ch_cnt_q, ch_cnt_d;
  logic                  bn_valid_q, bn_valid_d;
  logic                  bn_last_q, bn_last_d;
  logic [VW-1:0]         bn_x_q, bn_x_d;
  logic [DATA_WIDTH-1:0] bn_gamma_q, bn_gamma_d;
  logic [DATA_WIDTH-1:0] bn_beta_q, bn_beta_d;
  logic [BN_LATENCY-1:0] sr_vld_q, sr_vld_d;
  logic [BN_LATENCY-1:0] sr_last_q, sr_last_d;
  logic                  done_q, done_d;

  logic [SW-1:0]         inflight_s, credit_s;
  logic [FW-1:0]         fifo_count_s;
  logic                  issue_s, final_s, pop_s, fifo_valid_s;
  logic [VW:0]           fifo_head_s;

  // The valid stage is counted as in flight so a credit is consumed the cycle after issue.
  always_comb begin
    inflight_s = {{(SW-1){1'b0}}, bn_valid_q};
    for (int i = 0; i < BN_LATENCY; i++) begin
      inflight_s = inflight_s + {{(SW-1){1'b0}}, sr_vld_q[i]};
    end
    credit_s = inflight_s + SW'(fifo_count_s);
  end

  assign in_ready = (state_q == ST_RUN) && (credit_s < SW'(FIFO_DEPTH));
  assign issue_s  = in_valid && in_ready;
  assign pop_s    = fifo_valid_s && out_ready;
  assign final_s  = (ch_cnt_q == CW'(CHANNELS - 1)) && (vec_cnt_q == (vpc_q - 16'd1));

  // Next-state logic for the frame FSM, counters, issue stage and tag pipeline.
  always_comb begin
    state_d    = state_q;
    vpc_d      = vpc_q;
    vec_cnt_d  = vec_cnt_q;
    ch_cnt_d   = ch_cnt_q;
    bn_x_d     = bn_x_q;
    bn_gamma_d = bn_gamma_q;
    bn_beta_d  = bn_beta_q;
    done_d     = 1'b0;
    sr_vld_d   = {sr_vld_q[BN_LATENCY-2:0], bn_valid_q};
    sr_last_d  = {sr_last_q[BN_LATENCY-2:0], bn_last_q};
    bn_valid_d = issue_s;
    bn_last_d  = issue_s && final_s;

    if (issue_s) begin
      bn_x_d = in_data;
      // A same-cycle table write to the active channel is forwarded into this issue.
      if (cfg_we && (cfg_addr == ch_cnt_q)) begin
        bn_gamma_d = cfg_gamma;
        bn_beta_d  = cfg_beta;
      end else begin
        bn_gamma_d = gamma_mem_q[ch_cnt_q];
        bn_beta_d  = beta_mem_q[ch_cnt_q];
      end
      if (vec_cnt_q == (vpc_q - 16'd1)) begin
        vec_cnt_d = 16'd0;
        ch_cnt_d  = ch_cnt_q + CW'(1);
      end else begin
        vec_cnt_d = vec_cnt_q + 16'd1;
        ch_cnt_d  = ch_cnt_q;
      end
    end else begin
      vec_cnt_d = vec_cnt_q;
      ch_cnt_d  = ch_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          vpc_d     = eff_vpc(vec_per_ch);
          vec_cnt_d = 16'd0;
          ch_cnt_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (issue_s && final_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (pop_s && fifo_head_s[VW]) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Scheduler state registers; reset abandons any frame without signalling done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      vpc_q      <= 16'd1;
      vec_cnt_q  <= 16'd0;
      ch_cnt_q   <= '0;
      bn_valid_q <= 1'b0;
      bn_last_q  <= 1'b0;
      bn_x_q     <= '0;
      bn_gamma_q <= FP16_ZERO[DATA_WIDTH-1:0];
      bn_beta_q  <= FP16_ZERO[DATA_WIDTH-1:0];
      sr_vld_q   <= '0;
      sr_last_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vpc_q      <= vpc_d;
      vec_cnt_q  <= vec_cnt_d;
      ch_cnt_q   <= ch_cnt_d;
      bn_valid_q <= bn_valid_d;
      bn_last_q  <= bn_last_d;
      bn_x_q     <= bn_x_d;
      bn_gamma_q <= bn_gamma_d;
      bn_beta_q  <= bn_beta_d;
      sr_vld_q   <= sr_vld_d;
      sr_last_q  <= sr_last_d;
      done_q     <= done_d;
    end
  end

  // Gamma/beta table survives reset and may be written in any state.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      gamma_mem_q[cfg_addr] <= cfg_gamma;
      beta_mem_q[cfg_addr]  <= cfg_beta;
    end
  end

  bn_sched_fifo #(
    .WIDTH (VW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (sr_vld_q[BN_LATENCY-1]),
    .push_data ({sr_last_q[BN_LATENCY-1], bn_out}),
    .pop       (pop_s),
    .out_valid (fifo_valid_s),
    .out_data  (fifo_head_s),
    .count     (fifo_count_s)
  );

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign bn_valid  = bn_valid_q;
  assign bn_x      = bn_x_q;
  assign bn_gamma  = bn_gamma_q;
  assign bn_beta   = bn_beta_q;
  assign out_valid = fifo_valid_s;
  assign out_data  = fifo_head_s[VW-1:0];
  assign out_last  = fifo_head_s[VW];

`ifdef BN_SCHED_PERF_EN
  logic [31:0] stall_in_q, stall_in_d;
  logic [31:0] stall_out_q, stall_out_d;

  // Stall accounting, restarted with each accepted frame start.
  always_comb begin
    if ((state_q == ST_IDLE) && start) begin
      stall_in_d  = 32'd0;
      stall_out_d = 32'd0;
    end else begin
      stall_in_d  = stall_in_q + (((state_q == ST_RUN) && in_valid && !in_ready) ? 32'd1 : 32'd0);
      stall_out_d = stall_out_q + ((fifo_valid_s && !out_ready) ? 32'd1 : 32'd0);
    end
  end

  // Stall counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_in_q  <= 32'd0;
      stall_out_q <= 32'd0;
    end else begin
      stall_in_q  <= stall_in_d;
      stall_out_q <= stall_out_d;
    end
  end

  assign stall_in_cnt  = stall_in_q;
  assign stall_out_cnt = stall_out_q;
`endif

endmodule

// File: tb/tb_bn_scheduler.sv
// Scoreboard bench for bn_scheduler: random traffic against a frame-level reference model,
// with a delayed stand-in datapath; checks issue side and output side independently.
module tb_bn_scheduler;
  import bn_pkg::*;

  localparam int DW  = 16;
  localparam int SZ  = 4;
  localparam int CH  = 2;
  localparam int LAT = 8;
  localparam int FD  = 16;
  localparam int VW  = DW * SZ;
  localparam int CW  = $clog2(CH);

  logic          clk, reset, start, busy, done;
  logic [15:0]   vec_per_ch;
  logic          cfg_we;
  logic [CW-1:0] cfg_addr;
  logic [DW-1:0] cfg_gamma, cfg_beta;
  logic          in_valid, in_ready;
  logic [VW-1:0] in_data;
  logic          bn_valid;
  logic [VW-1:0] bn_x, bn_out;
  logic [DW-1:0] bn_gamma, bn_beta;
  logic          out_valid, out_ready, out_last;
  logic [VW-1:0] out_data;
`ifdef BN_SCHED_PERF_EN
  logic [31:0]   stall_in_cnt, stall_out_cnt;
`endif

  bn_scheduler #(
    .DATA_WIDTH (DW), .SIZE (SZ), .CHANNELS (CH), .BN_LATENCY (LAT), .FIFO_DEPTH (FD)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .vec_per_ch (vec_per_ch),
    .busy (busy), .done (done), .cfg_we (cfg_we), .cfg_addr (cfg_addr),
    .cfg_gamma (cfg_gamma), .cfg_beta (cfg_beta), .in_valid (in_valid),
    .in_ready (in_ready), .in_data (in_data), .bn_valid (bn_valid), .bn_x (bn_x),
    .bn_gamma (bn_gamma), .bn_beta (bn_beta), .bn_out (bn_out),
    .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
    .out_last (out_last)
`ifdef BN_SCHED_PERF_EN
    , .stall_in_cnt (stall_in_cnt), .stall_out_cnt (stall_out_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: table image, frame geometry and expectation queues.
  logic [DW-1:0]      g_tbl [CH];
  logic [DW-1:0]      b_tbl [CH];
  logic               dp_pass;
  int                 vpc_m, issue_idx, issue_cnt, out_cnt, done_cnt, last_cnt, ch_v;
  logic [VW+2*DW-1:0] exp_iss [$];
  logic [VW:0]        exp_out [$];
  logic [DW-1:0]      gam_seen [$];
  logic [VW+2*DW-1:0] e_iss;
  logic [VW:0]        e_out, hold_val;
  logic               hold_pend, lst_v;

  // Datapath stand-in: pass-through, or a lane mix of x with gamma/beta.
  function automatic logic [VW-1:0] dp_fn(input logic [VW-1:0] x, input logic [DW-1:0] g,
                                          input logic [DW-1:0] b, input logic pass);
    logic [VW-1:0] r;
    for (int i = 0; i < SZ; i++)
      r[i*DW +: DW] = pass ? x[i*DW +: DW] : (x[i*DW +: DW] ^ g ^ {b[7:0], b[15:8]});
    return r;
  endfunction

  logic [VW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= dp_fn(bn_x, bn_gamma, bn_beta, dp_pass);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bn_out = pipe[LAT-1];

  // Monitor: table image, issue prediction, and both scoreboards.
  always @(negedge clk) begin
    if (cfg_we) begin
      g_tbl[cfg_addr] = cfg_gamma;
      b_tbl[cfg_addr] = cfg_beta;
    end
    if (!reset) begin
      hold_pend = 1'b0;
    end else begin
      if (bn_valid) begin
        checks++;
        if (exp_iss.size() == 0) begin
          errors++;
          $display("FAIL bn_issue: unexpected bn_valid x=%h g=%h b=%h", bn_x, bn_gamma, bn_beta);
        end else begin
          e_iss = exp_iss.pop_front();
          if ({bn_x, bn_gamma, bn_beta} !== e_iss) begin
            errors++;
            $display("FAIL bn_issue: got %h expected %h", {bn_x, bn_gamma, bn_beta}, e_iss);
          end
        end
        gam_seen.push_back(bn_gamma);
      end
      if (in_valid && in_ready) begin
        checks++;
        if (issue_idx >= CH * vpc_m) begin
          errors++;
          $display("FAIL issue_overrun: issue index %0d, frame holds %0d", issue_idx, CH * vpc_m);
        end
        ch_v  = issue_idx / vpc_m;
        if (ch_v >= CH) ch_v = CH - 1;
        lst_v = (issue_idx == CH * vpc_m - 1);
        exp_iss.push_back({in_data, g_tbl[ch_v], b_tbl[ch_v]});
        exp_out.push_back({lst_v, dp_fn(in_data, g_tbl[ch_v], b_tbl[ch_v], dp_pass)});
        issue_idx++;
        issue_cnt++;
      end
      if (hold_pend) begin
        checks++;
        if (!out_valid || ({out_last, out_data} !== hold_val)) begin
          errors++;
          $display("FAIL out_hold: got v=%b %h expected v=1 %h", out_valid, {out_last, out_data}, hold_val);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_out.size() == 0) begin
          errors++;
          $display("FAIL out_data: unexpected output %h", {out_last, out_data});
        end else begin
          e_out = exp_out.pop_front();
          if ({out_last, out_data} !== e_out) begin
            errors++;
            $display("FAIL out_data: got last=%b %h expected last=%b %h", out_last, out_data, e_out[VW], e_out[VW-1:0]);
          end
        end
        out_cnt++;
        if (out_last) last_cnt++;
      end
      hold_pend = out_valid && !out_ready;
      hold_val  = {out_last, out_data};
      if (done) done_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input int ch, input logic [DW-1:0] g, input logic [DW-1:0] b);
    cfg_we = 1'b1; cfg_addr = CW'(ch); cfg_gamma = g; cfg_beta = b;
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic start_frame(input logic [15:0] v);
    vec_per_ch = v;
    vpc_m      = (v == 16'd0) ? 1 : int'(v);
    issue_idx  = 0;
    start      = 1'b1;
    tick(1);
    start      = 1'b0;
  endtask

  // Drive random traffic until the frame's done pulse, then verify frame-level outcome.
  task automatic run_frame(input int pin, input int pout, input int pcfg, input bit fixed,
                           input bit poke_start, input string name);
    int d0, l0, n;
    d0 = done_cnt; l0 = last_cnt; n = 0;
    while (done_cnt == d0 && n < 3000) begin
      in_valid = ($urandom_range(99) < pin);
      if (!fixed) in_data = {$urandom, $urandom};
      out_ready = ($urandom_range(99) < pout);
      cfg_we = ($urandom_range(99) < pcfg);
      cfg_addr = CW'($urandom_range(CH - 1));
      cfg_gamma = DW'($urandom); cfg_beta = DW'($urandom);
      start = poke_start && (n == 3);
      tick(1);
      n++;
    end
    cfg_we = 1'b0; in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s_timeout: no done after %0d cycles", name, n);
    end
    tick(4);
    check({name, "_done_once"}, 128'(done_cnt - d0), 128'd1);
    check({name, "_last_once"}, 128'(last_cnt - l0), 128'd1);
    check({name, "_issues"}, 128'(issue_idx), 128'(CH * vpc_m));
    check({name, "_drained"}, 128'(exp_out.size()), 128'd0);
    check({name, "_idle"}, {127'd0, busy}, 128'd0);
  endtask

  int ic0, oc0, dc0, n;
  logic [VW-1:0] vec_a;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; vec_per_ch = 16'd1; cfg_we = 1'b0; cfg_addr = '0;
    cfg_gamma = '0; cfg_beta = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    dp_pass = 1'b1; vpc_m = 1; issue_idx = 0; issue_cnt = 0; out_cnt = 0;
    done_cnt = 0; last_cnt = 0; hold_pend = 1'b0;
    tick(3);
    check("reset_ctrl", {122'd0, busy, done, in_ready, bn_valid, out_valid, out_last}, 128'd0);
    check("reset_bn_x", 128'(bn_x), 128'd0);
    check("reset_gb", 128'({bn_gamma, bn_beta}), 128'd0);
    check("reset_out_data", 128'(out_data), 128'd0);
    reset = 1'b1;
    tick(2);
    check("idle_after_reset", {126'd0, busy, in_ready}, 128'd0);

    // Basic pass-through frame: four identical vectors, unity gamma.
    dp_pass = 1'b1;
    cfg_write(0, FP16_ONE, FP16_ZERO);
    cfg_write(1, FP16_ONE, FP16_ZERO);
    vec_a = 64'h4000_4200_4400_4500;
    in_data = vec_a;
    oc0 = out_cnt;
    start_frame(16'd2);
    check("basic_busy", {127'd0, busy}, 128'd1);
    run_frame(100, 100, 0, 1'b1, 1'b0, "basic");
    check("basic_outputs", 128'(out_cnt - oc0), 128'd4);

    // Channel switch: gamma must change from the third issue on.
    dp_pass = 1'b0;
    cfg_write(0, 16'h3C00, 16'h1234);
    cfg_write(1, 16'h3400, 16'h5678);
    gam_seen.delete();
    start_frame(16'd2);
    run_frame(100, 100, 0, 1'b0, 1'b0, "chsw");
    check("chsw_count", 128'(gam_seen.size()), 128'd4);
    if (gam_seen.size() == 4) begin
      check("chsw_gamma2", 128'(gam_seen[1]), 128'h3C00);
      check("chsw_gamma3", 128'(gam_seen[2]), 128'h3400);
    end

    // Backpressure: 40 stalled cycles allow exactly FIFO_DEPTH issues.
    start_frame(16'd20);
    ic0 = issue_cnt;
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      in_data = {$urandom, $urandom};
      tick(1);
    end
    check("bp_issue_count", 128'(issue_cnt - ic0), 128'(FD));
    check("bp_in_ready_low", {127'd0, in_ready}, 128'd0);
    check("bp_out_valid", {127'd0, out_valid}, 128'd1);
    // Release with continuous input so pushes and pops coincide at full occupancy.
    run_frame(100, 100, 0, 1'b0, 1'b0, "bp");

    // Reset while the third issue is presented.
    start_frame(16'd2);
    ic0 = issue_cnt; dc0 = done_cnt; n = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    while ((issue_cnt - ic0) < 2 && n < 50) begin
      in_data = {$urandom, $urandom};
      tick(1);
      n++;
    end
    check("rst_mid_two_issues", 128'(issue_cnt - ic0), 128'd2);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_ctrl", {122'd0, busy, done, in_ready, bn_valid, out_valid, out_last}, 128'd0);
    check("rst_mid_data", 128'({bn_x, bn_gamma, bn_beta} | 96'(out_data)), 128'd0);
    exp_iss.delete(); exp_out.delete();
    in_valid = 1'b0;
    tick(4);
    reset = 1'b1;
    tick(12);
    check("rst_mid_no_done", 128'(done_cnt - dc0), 128'd0);
    check("rst_mid_issue_lost", 128'(issue_cnt - ic0), 128'd2);
    cfg_write(0, 16'h3C00, 16'h0000);
    cfg_write(1, 16'h3800, 16'h0101);
    start_frame(16'd3);
    run_frame(80, 80, 0, 1'b0, 1'b0, "post_rst");

    // Random frames: mixed sizes including zero, random cfg writes, a stray start.
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < CH; c++) cfg_write(c, DW'($urandom), DW'($urandom));
      case (f)
        0: start_frame(16'd0);
        1: start_frame(16'd1);
        2: start_frame(16'd5);
        default: start_frame(16'($urandom_range(2, 9)));
      endcase
      run_frame(70, 60, 10, 1'b0, (f >= 2), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bn_scheduler.md
BN_SCHEDULER -- requirements
Module: bn_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, fp16 element width.
REQ-002 SHALL have parameter SIZE, default 4, elements per vector.
REQ-003 SHALL have parameter CHANNELS, default 16, channel count, which sizes the gamma/beta table.
REQ-004 SHALL have parameter BN_LATENCY, default 8, fixed BN datapath latency in cycles.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, output buffer entries (power of two, >= BN_LATENCY).
REQ-006 SHALL have ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a frame.
- vec_per_ch  in  16  vectors per channel, 0 treated as 1.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when the last vector has been accepted downstream.
- cfg_we  in  1  gamma/beta table write strobe.
- cfg_addr  in  $clog2(CHANNELS)  table write address.
- cfg_gamma  in  DATA_WIDTH  gamma value.
- cfg_beta  in  DATA_WIDTH  beta value.
- in_valid  in  1  input vector valid.
- in_ready  out  1  scheduler can accept an input vector.
- in_data  in  DATA_WIDTH*SIZE  input vector.
- bn_valid  out  1  issue strobe to the BN datapath.
- bn_x  out  DATA_WIDTH*SIZE  vector issued to the datapath.
- bn_gamma  out  DATA_WIDTH  gamma for the current channel.
- bn_beta  out  DATA_WIDTH  beta for the current channel.
- bn_out  in  DATA_WIDTH*SIZE  datapath result.
- out_valid  out  1  output vector valid.
- out_ready  in  1  downstream can accept the output vector.
- out_data  out  DATA_WIDTH*SIZE  output vector.
- out_last  out  1  marks the final vector of the frame.

Function
REQ-007 SHALL implement FSM IDLE -> RUN on start; RUN -> DRAIN when the final vector issues; DRAIN -> IDLE when the final vector is accepted downstream, pulsing done.
REQ-008 SHALL ignore start outside IDLE.
REQ-009 SHALL assert busy in RUN and DRAIN only.
REQ-010 SHALL set in_ready = (state==RUN) && (inflight + fifo_count < FIFO_DEPTH); an issue occurs on in_valid && in_ready.
REQ-011 SHALL, on issue, register bn_valid=1 and bn_x=in_data, with bn_gamma/bn_beta read from the current channel entry, all valid together on the next cycle.
REQ-012 SHALL track issues with a BN_LATENCY-deep valid shift register; bn_out SHALL be captured into the FIFO exactly BN_LATENCY cycles after bn_valid.
REQ-013 SHALL keep inflight = popcount of the shift register; the credit rule SHALL guarantee that the FIFO never overflows, so no result is ever dropped.
REQ-014 SHALL increment the vector counter per issue; at vec_per_ch-1 it SHALL wrap to 0 and the channel counter SHALL increment.
REQ-015 SHALL treat the issue at channel CHANNELS-1 with vector vec_per_ch-1 as final, carrying its tag through the shift register to out_last.
REQ-016 SHALL present out_data and out_valid from the FIFO head, first-word-fall-through.
REQ-017 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-018 SHALL, on simultaneous FIFO push and pop when full or empty, perform both with the count unchanged.
REQ-019 SHALL write the table on cfg_we in any state; a write to the active channel during RUN SHALL take effect on the next issue.

Reset
REQ-020 SHALL, on reset low, immediately enter IDLE; clear counters, FIFO and shift register; and drive busy, done, in_ready, bn_valid, out_valid and out_last to 0, with bn_x, bn_gamma, bn_beta and out_data at 0.
REQ-021 SHALL NOT clear the gamma/beta table on reset; after reset the table SHALL be reloaded by cfg before start.
REQ-022 SHALL discard all in-flight data on reset mid-frame and SHALL NOT pulse done.

Configuration
REQ-023 SHALL, with BN_SCHED_PERF_EN defined, add outputs stall_in_cnt[31:0] (cycles in RUN with in_valid && !in_ready) and stall_out_cnt[31:0] (cycles with out_valid && !out_ready), cleared on start and reset.
REQ-024 SHALL, without BN_SCHED_PERF_EN, omit those ports and counters.

Structure
REQ-025 SHALL place the FSM state enum, the fp16 constants (ONE=16'h3C00, ZERO=16'h0000) and the default widths in the shared package bn_pkg.
REQ-026 SHALL implement the output buffer as a sub-module bn_sched_fifo with parameters WIDTH and DEPTH.

Verification
REQ-027 Basic: load gamma=16'h3C00 and beta=0 for all channels, vec_per_ch=2, CHANNELS=2, datapath model = pass-through delayed 8 cycles, feed 4 vectors 64'h4000_4200_4400_4500 -> 4 outputs equal to the inputs in order, out_last on the 4th, done once.
REQ-028 Backpressure: out_ready=0 for 40 cycles -> in_ready drops after exactly 16 issues, no loss, correct order after release.
REQ-029 Channel switch: ch0 gamma=16'h3C00, ch1 gamma=16'h3400 -> bn_gamma changes on the 3rd issue with vec_per_ch=2.
REQ-030 Simultaneous push/pop: full FIFO with out_ready=1 and a capture in the same cycle -> count stays at 16.
REQ-031 Reset mid-frame: reset low during the 3rd issue -> all outputs 0 immediately, no done; a new start runs cleanly.
